// File: rtl/ahb_arbiter_if.sv
// ============================================================================
// Module   : ahb_arbiter_if
// Brief    : AHB arbitration bundle: requests and bus status in, grant out.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ahb_arbiter_if #(
   parameter int NUM_MASTERS = 4
);
   logic [NUM_MASTERS-1:0] HBUSREQ;
   logic [NUM_MASTERS-1:0] HLOCK;
   logic [1:0]             HTRANS;
   logic [2:0]             HBURST;
   logic                   HREADY;
   logic [1:0]             HRESP;
   logic [NUM_MASTERS-1:0] HGRANT;
   logic [2:0]             HMASTER;
   logic                   HMASTLOCK;

   modport master (
      output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
      input  HGRANT, HMASTER, HMASTLOCK
   );

   modport slave (
      input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
      output HGRANT, HMASTER, HMASTLOCK
   );
endinterface

`default_nettype wire

// File: rtl/ahb_arbiter.sv
// ============================================================================
// Module   : ahb_arbiter
// Brief    : Round-robin AHB arbiter with fixed-burst and locked-transfer hold.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ahb_arbiter #(
   parameter int NUM_MASTERS    = 4,
   parameter int DEFAULT_MASTER = 0
) (
   input  logic          HCLK,
   input  logic          HRESET,
   ahb_arbiter_if.slave  bus
);

   localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] c_HTRANS_SEQ    = 2'b11;
   localparam logic [1:0] c_HRESP_ERROR   = 2'b01;
   localparam logic [2:0] c_DEFAULT_IDX   = 3'(DEFAULT_MASTER);
   localparam logic [NUM_MASTERS-1:0] c_DEFAULT_GRANT =
      NUM_MASTERS'(1) << DEFAULT_MASTER;

   typedef enum logic [1:0] {
      ST_ARB    = 2'd0,
      ST_BURST  = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [3:0]             r_cnt;
   logic [3:0]             w_cnt_nxt;
   logic [2:0]             r_ptr;
   logic [2:0]             w_ptr_nxt;
   logic [NUM_MASTERS-1:0] r_grant;
   logic [NUM_MASTERS-1:0] w_grant_nxt;
   logic [2:0]             r_master;
   logic                   r_mastlock;

   logic                   w_accept;
   logic                   w_error;
   logic                   w_fixed_burst;
   logic [3:0]             w_burst_cnt;
   logic                   w_owner_lock;
   logic [2:0]             w_owner;
   logic                   w_found;
   logic [2:0]             w_winner;
   logic [3:0]             w_dist;
   logic [3:0]             w_best;

   assign w_accept      = bus.HREADY;
   assign w_error       = (bus.HRESP == c_HRESP_ERROR) && !bus.HREADY;
   assign w_fixed_burst = (bus.HTRANS == c_HTRANS_NONSEQ) && (bus.HBURST >= 3'd2);
   assign w_owner_lock  = |(bus.HLOCK & r_grant);

   always_comb begin
      case (bus.HBURST)
         3'd2, 3'd3: w_burst_cnt = 4'd3;
         3'd4, 3'd5: w_burst_cnt = 4'd7;
         3'd6, 3'd7: w_burst_cnt = 4'd15;
         default:    w_burst_cnt = 4'd0;
      endcase
   end

   always_comb begin
      w_owner = c_DEFAULT_IDX;
      for (int j = 0; j < NUM_MASTERS; j++) begin
         if (r_grant[j]) begin
            w_owner = 3'(j);
         end
      end
   end

   // Distance 0 is the master just after the pointer; the pointer itself is last.
   always_comb begin
      w_found  = 1'b0;
      w_winner = c_DEFAULT_IDX;
      w_best   = 4'd15;
      w_dist   = 4'd0;
      for (int j = 0; j < NUM_MASTERS; j++) begin
         w_dist = 4'((j + 2 * NUM_MASTERS - 1 - int'(r_ptr)) % NUM_MASTERS);
         if (bus.HBUSREQ[j] && (w_dist < w_best)) begin
            w_found  = 1'b1;
            w_best   = w_dist;
            w_winner = 3'(j);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_grant_nxt = r_grant;
      w_ptr_nxt   = r_ptr;
      if (w_error) begin
         w_state_nxt = ST_ARB;
         w_cnt_nxt   = 4'd0;
      end else if (w_accept) begin
         case (r_state)
            ST_ARB: begin
               if (w_fixed_burst) begin
                  w_state_nxt = ST_BURST;
                  w_cnt_nxt   = w_burst_cnt;
               end else if (w_owner_lock) begin
                  w_state_nxt = ST_LOCKED;
               end else if (w_found) begin
                  w_grant_nxt = NUM_MASTERS'(1) << w_winner;
                  w_ptr_nxt   = w_winner;
               end else begin
                  w_grant_nxt = c_DEFAULT_GRANT;
               end
            end
            ST_BURST: begin
               if (bus.HTRANS == c_HTRANS_SEQ) begin
                  w_cnt_nxt = r_cnt - 4'd1;
                  if (r_cnt <= 4'd1) begin
                     w_state_nxt = ST_ARB;
                     w_cnt_nxt   = 4'd0;
                  end
               end
            end
            ST_LOCKED: begin
               // HTRANS[0] set means SEQ or BUSY: the locked sequence continues.
               if (!w_owner_lock && !bus.HTRANS[0]) begin
                  w_state_nxt = ST_ARB;
               end
            end
            default: begin
               w_state_nxt = ST_ARB;
               w_cnt_nxt   = 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_state    <= ST_ARB;
         r_cnt      <= 4'd0;
         r_ptr      <= c_DEFAULT_IDX;
         r_grant    <= c_DEFAULT_GRANT;
         r_master   <= c_DEFAULT_IDX;
         r_mastlock <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ptr   <= w_ptr_nxt;
         r_grant <= w_grant_nxt;
         if (w_accept) begin
            r_master   <= w_owner;
            r_mastlock <= w_owner_lock;
         end
      end
   end

   assign bus.HGRANT    = r_grant;
   assign bus.HMASTER   = r_master;
   assign bus.HMASTLOCK = r_mastlock;

endmodule

`default_nettype wire

// File: tb/tb_ahb_arbiter.sv
// ============================================================================
// Module   : tb_ahb_arbiter
// Brief    : Directed and randomized bench for ahb_arbiter with a reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ahb_arbiter;

   localparam int N   = 4;
   localparam int DEF = 0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference model: beats left in a fixed burst, lock flag, grant owner.
   int   m_owner  = DEF;
   int   m_ptr    = DEF;
   int   m_master = DEF;
   int   m_beats  = 0;
   bit   m_locked = 1'b0;
   bit   m_mlock  = 1'b0;

   ahb_arbiter_if #(.NUM_MASTERS(N)) bus ();

   ahb_arbiter #(
      .NUM_MASTERS    (N),
      .DEFAULT_MASTER (DEF)
   ) u_dut (
      .HCLK   (clk),
      .HRESET (rst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic drive(input logic [3:0] req, input logic [3:0] lk, input logic [1:0] tr,
                        input logic [2:0] bu, input logic rdy, input logic [1:0] rsp);
      bus.HBUSREQ = req;
      bus.HLOCK   = lk;
      bus.HTRANS  = tr;
      bus.HBURST  = bu;
      bus.HREADY  = rdy;
      bus.HRESP   = rsp;
   endtask

   task automatic model_edge();
      bit own_lock;
      int prev;
      int win;
      int c;
      if (rst) begin
         m_owner = DEF; m_ptr = DEF; m_master = DEF;
         m_mlock = 1'b0; m_beats = 0; m_locked = 1'b0;
      end else if (bus.HRESP == 2'b01 && !bus.HREADY) begin
         m_beats  = 0;
         m_locked = 1'b0;
      end else if (bus.HREADY) begin
         own_lock = ((bus.HLOCK >> m_owner) & 4'b0001) != 4'b0000;
         prev     = m_owner;
         if (m_beats > 0) begin
            if (bus.HTRANS == 2'b11) m_beats--;
         end else if (m_locked) begin
            if (!own_lock && bus.HTRANS != 2'b11 && bus.HTRANS != 2'b01) m_locked = 1'b0;
         end else if (bus.HTRANS == 2'b10 && int'(bus.HBURST) >= 2) begin
            m_beats = (4 << ((int'(bus.HBURST) - 2) / 2)) - 1;
         end else if (own_lock) begin
            m_locked = 1'b1;
         end else begin
            win = -1;
            for (int k = 1; k <= N; k++) begin
               c = (m_ptr + k) % N;
               if (win < 0 && (((bus.HBUSREQ >> c) & 4'b0001) != 4'b0000)) win = c;
            end
            if (win >= 0) begin
               m_owner = win;
               m_ptr   = win;
            end else begin
               m_owner = DEF;
            end
         end
         m_master = prev;
         m_mlock  = own_lock;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("HGRANT",    32'(bus.HGRANT),    32'(1) << m_owner);
      chk("HMASTER",   32'(bus.HMASTER),   32'(m_master));
      chk("HMASTLOCK", 32'(bus.HMASTLOCK), 32'(m_mlock));
      chk("onehot",    32'($onehot(bus.HGRANT)), 32'd1);
   endtask

   logic [1:0] t37_tr  [7] = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b00};
   logic       t37_rdy [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
   logic [3:0] t37_g   [7] = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h4};

   initial begin
      logic [3:0] lk;
      drive(4'b0000, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00);
      rst = 1'b1;
      step();
      step();
      chk("reset_grant",  32'(bus.HGRANT),  32'h1);
      chk("reset_master", 32'(bus.HMASTER), 32'h0);
      rst = 1'b0;

      for (int k = 0; k < 5; k++) begin
         step();
         chk("idle_grant",  32'(bus.HGRANT),    32'h1);
         chk("idle_master", 32'(bus.HMASTER),   32'h0);
         chk("idle_lock",   32'(bus.HMASTLOCK), 32'h0);
      end

      drive(4'b0110, 4'b0000, 2'b10, 3'b000, 1'b1, 2'b00);
      for (int k = 0; k < 6; k++) begin
         step();
         chk("rr_grant",  32'(bus.HGRANT), (k % 2 == 0) ? 32'h2 : 32'h4);
         chk("rr_master", 32'(bus.HMASTER), (k == 0) ? 32'h0 : ((k % 2 == 1) ? 32'h1 : 32'h2));
      end

      drive(4'b0010, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00);
      step();
      step();
      for (int i = 0; i < 7; i++) begin
         drive(4'b0110, 4'b0000, t37_tr[i], 3'b011, t37_rdy[i], 2'b00);
         step();
         chk("incr4_grant", 32'(bus.HGRANT), 32'(t37_g[i]));
      end

      drive(4'b1000, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00);
      step();
      step();
      drive(4'b1111, 4'b1000, 2'b10, 3'b000, 1'b1, 2'b00);
      for (int k = 0; k < 6; k++) begin
         step();
         chk("lock_grant", 32'(bus.HGRANT),    32'h8);
         chk("lock_mlock", 32'(bus.HMASTLOCK), 32'h1);
      end
      drive(4'b1111, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00);
      step();
      chk("unlock_hold", 32'(bus.HGRANT), 32'h8);
      step();
      chk("unlock_move", 32'(bus.HGRANT), 32'h1);

      drive(4'b0001, 4'b0000, 2'b10, 3'b100, 1'b1, 2'b00);
      step();
      drive(4'b0001, 4'b0000, 2'b11, 3'b100, 1'b1, 2'b00);
      step();
      drive(4'b0011, 4'b0000, 2'b11, 3'b100, 1'b0, 2'b01);
      step();
      chk("err_hold", 32'(bus.HGRANT), 32'h1);
      drive(4'b0011, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00);
      step();
      chk("err_rearb", 32'(bus.HGRANT), 32'h2);

      drive(4'b0100, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00);
      step();
      drive(4'b0100, 4'b0000, 2'b10, 3'b111, 1'b1, 2'b00);
      step();
      drive(4'b0100, 4'b0000, 2'b11, 3'b111, 1'b1, 2'b00);
      step();
      rst = 1'b1;
      step();
      chk("rst_burst_grant",  32'(bus.HGRANT),    32'h1);
      chk("rst_burst_master", 32'(bus.HMASTER),   32'h0);
      chk("rst_burst_mlock",  32'(bus.HMASTLOCK), 32'h0);
      rst = 1'b0;
      drive(4'b0100, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00);
      step();
      chk("rst_burst_arb", 32'(bus.HGRANT), 32'h4);

      for (int k = 0; k < 400; k++) begin
         for (int b = 0; b < N; b++) lk[b] = ($urandom % 8 == 0);
         drive(4'($urandom), lk, 2'($urandom), 3'($urandom),
               ($urandom % 4 != 0), ($urandom % 8 == 0) ? 2'b01 : 2'b00);
         rst = ($urandom % 100 == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
